// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder.
//   OP_W           : operand width driven to the downstream MAC
//   FIFO_DEPTH_DEF : default depth of the operand-pair buffer
//   state_e        : feeder FSM states
package mac_pkg;

  localparam int OP_W           = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_op_fifo.sv
// Synchronous single-clock FIFO holding operand pairs for the MAC feeder.
// No bypass: a word written on one edge is readable from the next cycle on.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push       : write push_data (ignored while full)
//   push_data  : word to write
//   full       : no free entry
//   pop        : advance read pointer (ignored while empty)
//   pop_data   : word at the head, valid while !empty
//   empty      : no stored entry
module mac_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mac_feed_ctrl.sv
// Feeds buffered operand pairs to a downstream MAC for one dot product.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   in_vld/in_rdy   : operand-pair handshake, in_A/in_B the pair
//   start, len      : begin a dot product of len pairs (len sampled at start)
//   busy            : FSM not in IDLE
//   done            : one-cycle pulse, downstream accum is final
//   A, B, en, clr   : registered operands and controls to the MAC
//
// state | meaning
// IDLE  | waiting for start; en=0
// CLEAR | one cycle of en=1 clr=1 A=B=0, clears the MAC
// RUN   | issue one popped pair per cycle, bubbles (en=0) when FIFO empty
// DRAIN | en=1 A=B=0, flushes the MAC product register into accum
// DONE  | done=1 en=0, then back to IDLE
module mac_feed_ctrl
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [OP_W-1:0]  in_A,
  input  logic [OP_W-1:0]  in_B,
  output logic             in_rdy,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [OP_W-1:0]  A,
  output logic [OP_W-1:0]  B,
  output logic             en,
  output logic             clr
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W-1:0]    b_q, b_d;
  logic               en_q, en_d;
  logic               clr_q, clr_d;
  logic               done_q, done_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [2*OP_W-1:0]  fifo_rdata;

  mac_op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2*OP_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_vld),
    .push_data ({in_A, in_B}),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty)
  );

  assign in_rdy = !fifo_full;
  assign busy   = (state_q != IDLE);
  assign A      = a_q;
  assign B      = b_q;
  assign en     = en_q;
  assign clr    = clr_q;
  assign done   = done_q;

  // Outputs are computed for the state being entered, so the registered
  // outputs always line up with state_q. The pop for the first pair is
  // already taken while in CLEAR, so issue cycles follow CLEAR directly.
  // In RUN, cnt_q == 0 means the last pair is on the MAC inputs right now.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = '0;
    b_d      = '0;
    en_d     = 1'b0;
    clr_d    = 1'b0;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = len;
          en_d    = 1'b1;
          clr_d   = 1'b1;
        end
      end
      CLEAR, RUN: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          en_d    = 1'b1;
        end else begin
          state_d = RUN;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cnt_d    = cnt_q - 1'b1;
            en_d     = 1'b1;
            a_d      = fifo_rdata[2*OP_W-1:OP_W];
            b_d      = fifo_rdata[OP_W-1:0];
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// Self-checking bench for mac_feed_ctrl with a behavioural downstream MAC.
module tb_mac_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vld = 1'b0;
  logic [7:0] in_A = '0;
  logic [7:0] in_B = '0;
  logic       in_rdy;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       busy, done, en, clr;
  logic [7:0] A, B;

  mac_feed_ctrl #(
    .FIFO_DEPTH (4),
    .LEN_W      (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (in_vld),
    .in_A   (in_A),
    .in_B   (in_B),
    .in_rdy (in_rdy),
    .start  (start),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .A      (A),
    .B      (B),
    .en     (en),
    .clr    (clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // downstream MAC: product register feeding an accumulator
  logic [31:0] acc_m = '0;
  logic [31:0] prod_m = '0;
  always @(posedge clk) begin
    if (en === 1'b1) begin
      if (clr) begin
        acc_m  <= '0;
        prod_m <= '0;
      end else begin
        acc_m  <= acc_m + prod_m;
        prod_m <= 32'(A) * 32'(B);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard of accepted pairs, in push order
  logic [15:0] sb_q[$];
  logic [15:0] p;
  int          run_len = 0;
  int          issued = 0;
  int          done_cnt = 0;
  int          bubbles = 0;
  int          last_issue_cyc = 0;
  int          clr_cyc = 0;
  int          done_cyc = 0;
  int          start_c = 0;
  logic [31:0] exp_sum = '0;
  bit          drain_seen = 1'b0;

  always @(negedge clk) begin
    if (clr === 1'b1) begin
      check("clr_en", en, 1);
      check("clr_ab", {A, B}, 0);
      check("clr_busy", busy, 1);
      issued     = 0;
      exp_sum    = '0;
      drain_seen = 1'b0;
      clr_cyc    = cyc;
    end else if (en === 1'b1) begin
      if (issued < run_len) begin
        if (sb_q.size() == 0) begin
          check("issue_without_pair", 1, 0);
        end else begin
          p = sb_q.pop_front();
          check("issue_a", A, p[15:8]);
          check("issue_b", B, p[7:0]);
          exp_sum = exp_sum + 32'(p[15:8]) * 32'(p[7:0]);
        end
        issued++;
        last_issue_cyc = cyc;
      end else begin
        check("drain_ab", {A, B}, 0);
        check("drain_once", drain_seen, 0);
        drain_seen = 1'b1;
      end
    end else if (busy === 1'b1 && done !== 1'b1) begin
      bubbles++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_en", en, 0);
      check("done_issues", issued, run_len);
      check("done_drain", drain_seen, 1);
      check("done_accum", acc_m, exp_sum);
      if (run_len > 0) check("issue_to_done", cyc - last_issue_cyc, 2);
      else             check("clr_to_done", cyc - clr_cyc, 2);
    end
  end

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_vld = 1'b1;
    in_A   = a;
    in_B   = b;
    while (!in_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) begin
      check("push_timeout", 0, 1);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back({a, b});
    #1 in_vld = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] l);
    @(negedge clk);
    start   = 1'b1;
    len     = l;
    run_len = l;
    @(posedge clk);
    #1 start = 1'b0;
    start_c = cyc;
  endtask

  task automatic wait_done(input int max_cyc);
    int base = done_cnt;
    int t = 0;
    while (done_cnt == base && t < max_cyc) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_cnt == base) check("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    run_len = 0;
    issued  = 0;
    check("rst_en", en, 0);
    check("rst_clr", clr, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ab", {A, B}, 0);
    check("rst_in_rdy", in_rdy, 1);
    rst_n = 1'b1;
  endtask

  int b0, d0;

  initial begin
    do_reset();

    // preloaded pairs, no bubbles, fixed latency
    push_pair(8'd2, 8'd3);
    push_pair(8'd4, 8'd5);
    push_pair(8'd255, 8'd255);
    b0 = bubbles;
    start_run(8'd3);
    wait_done(100);
    check("t34_latency", done_cyc - start_c, 5);
    check("t34_accum", acc_m, 65051);
    check("t34_bubbles", bubbles - b0, 0);

    // slow producer: bubbles between issues
    b0 = bubbles;
    fork
      begin
        start_run(8'd2);
        wait_done(200);
      end
      begin
        repeat (2) @(negedge clk);
        push_pair(8'd10, 8'd20);
        repeat (2) @(negedge clk);
        push_pair(8'd30, 8'd40);
      end
    join
    check("t35_accum", acc_m, 1400);
    check("t35_bubbled", (bubbles - b0) > 0, 1);

    // zero-length run
    start_run(8'd0);
    wait_done(50);
    check("t36_latency", done_cyc - start_c, 2);
    check("t36_accum", acc_m, 0);

    // full FIFO backpressure; leftover pairs stay for the next run
    push_pair(8'd1, 8'd2);
    push_pair(8'd3, 8'd4);
    push_pair(8'd5, 8'd6);
    push_pair(8'd7, 8'd8);
    @(negedge clk);
    check("t37_full", in_rdy, 0);
    fork
      push_pair(8'd9, 8'd10);
      begin
        start_run(8'd1);
        wait_done(100);
      end
    join
    check("t37_accum1", acc_m, 2);
    @(negedge clk);
    check("t37_full_again", in_rdy, 0);
    start_run(8'd4);
    wait_done(100);
    check("t37_accum2", acc_m, 188);
    check("t37_not_full", in_rdy, 1);

    // reset mid-run with one pair still buffered
    push_pair(8'd20, 8'd1);
    start_run(8'd4);
    push_pair(8'd21, 8'd1);
    push_pair(8'd22, 8'd1);
    check("t38_busy", busy, 1);
    do_reset();
    push_pair(8'd7, 8'd9);
    start_run(8'd1);
    wait_done(100);
    check("t38_accum", acc_m, 63);

    // start during RUN is ignored
    d0 = done_cnt;
    start_run(8'd2);
    repeat (3) @(negedge clk);
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    push_pair(8'd3, 8'd3);
    push_pair(8'd4, 8'd4);
    wait_done(100);
    check("t39_accum", acc_m, 25);
    repeat (12) @(negedge clk);
    check("t39_single_done", done_cnt - d0, 1);
    check("t39_idle", busy, 0);
    check("t39_fifo_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1);
  end

endmodule
